ysyx_23060332_lsu: RTL

Load/store unit: the initiator side of the core's data-memory port. It accepts one load or store at a time from the execute stage over a valid/ready handshake. It converts the request into word-aligned memory-port strobes, splitting any access that crosses a 4-byte boundary into two beats. It returns sign- or zero-extended load data, or a fault, over a valid/ready response channel.

---
 rtl/ysyx_23060332_lsu.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: single-outstanding data-memory initiator with split beats for
// accesses that cross a word boundary, sign/zero-extended load return and fault detection.
module ysyx_23060332_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  localparam logic [31:0] WIN_BASE = 32'h8000_0000;
  localparam logic [31:0] WIN_LAST = 32'h87ff_ffff;

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_lo, r_rdata;
  logic [1:0]  r_size;
  logic        r_uns, r_err;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= WIN_BASE) && (a <= WIN_LAST);
  endfunction

  // Fault decode on the incoming request (start and last byte must both be in the window)
  logic [2:0]  w_req_nbytes;
  logic [31:0] w_req_end;
  logic        w_fault;
  always_comb begin
    case (req_size)
      2'd0:    w_req_nbytes = 3'd1;
      2'd1:    w_req_nbytes = 3'd2;
      default: w_req_nbytes = 3'd4;
    endcase
    w_req_end = req_addr + 32'(w_req_nbytes) - 32'd1;
    w_fault   = (req_size == 2'd3) || !in_win(req_addr) || !in_win(w_req_end);
  end

  // Geometry of the latched request
  logic [1:0]  w_off;
  logic [2:0]  w_nbytes;
  logic [3:0]  w_bmask;
  logic        w_cross;
  logic [31:0] w_aligned;
  logic [63:0] w_wide_data;
  logic [7:0]  w_wide_mask;
  always_comb begin
    w_off = r_addr[1:0];
    case (r_size)
      2'd0:    begin w_nbytes = 3'd1; w_bmask = 4'h1; end
      2'd1:    begin w_nbytes = 3'd2; w_bmask = 4'h3; end
      default: begin w_nbytes = 3'd4; w_bmask = 4'hF; end
    endcase
    w_cross     = (({1'b0, w_off}) + w_nbytes) > 3'd4;
    w_aligned   = {r_addr[31:2], 2'b00};
    w_wide_data = {32'h0, r_wdata} << {w_off, 3'b000};
    w_wide_mask = {4'h0, w_bmask} << w_off;
  end

  // Load result: the beat being read now is combined with the captured low word
  logic [31:0] w_lo_src, w_hi_src, w_raw, w_ext;
  always_comb begin
    w_lo_src = (r_state == S_RD0) ? mem_rdata : r_lo;
    w_hi_src = (r_state == S_RD1) ? mem_rdata : 32'h0;
    w_raw    = 32'({w_hi_src, w_lo_src} >> {w_off, 3'b000});
    case (r_size)
      2'd0:    w_ext = r_uns ? {24'h0, w_raw[7:0]}  : {{24{w_raw[7]}}, w_raw[7:0]};
      2'd1:    w_ext = r_uns ? {16'h0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_ren    = 1'b0;
    mem_raddr  = 32'h0;
    mem_wen    = 1'b0;
    mem_waddr  = 32'h0;
    mem_wdata  = 32'h0;
    mem_wmask  = 8'h0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_fault)      w_next = S_RESP;
          else if (req_wen) w_next = S_WR0;
          else              w_next = S_RD0;
        end
      end
      S_RD0: begin
        mem_ren   = 1'b1;
        mem_raddr = w_aligned;
        w_next    = w_cross ? S_RD1 : S_RESP;
      end
      S_RD1: begin
        mem_ren   = 1'b1;
        mem_raddr = w_aligned + 32'd4;
        w_next    = S_RESP;
      end
      S_WR0: begin
        mem_wen   = 1'b1;
        mem_waddr = w_aligned;
        mem_wdata = w_wide_data[31:0];
        mem_wmask = {4'h0, w_wide_mask[3:0]};
        w_next    = w_cross ? S_WR1 : S_RESP;
      end
      S_WR1: begin
        mem_wen   = 1'b1;
        mem_waddr = w_aligned + 32'd4;
        mem_wdata = w_wide_data[63:32];
        mem_wmask = {4'h0, w_wide_mask[7:4]};
        w_next    = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_lo    <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_size  <= req_size;
          r_uns   <= req_unsigned;
          r_err   <= w_fault;
          r_rdata <= 32'h0;
        end
        S_RD0: begin
          r_lo <= mem_rdata;
          if (!w_cross) r_rdata <= w_ext;
        end
        S_RD1:  r_rdata <= w_ext;
        S_RESP: if (resp_ready) begin
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
